// File: rtl/cpu_memory_bus.sv
// CPU memory-bus responder: decodes each new core access and serves it from mirrored work RAM,
// an external PRG ROM port, or open bus for unmapped space. Result is a registered byte plus valid.
module cpu_memory_bus #(
  parameter int unsigned RAM_WAIT_STATES = 1,
  parameter int unsigned RAM_ADDR_WIDTH  = 11
) (
  input  logic        clock_i,
  input  logic        reset_n_i,
  input  logic [15:0] address_i,
  input  logic        address_valid_i,
  input  logic        write_i,
  input  logic [7:0]  write_data_i,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic [14:0] rom_address_o,
  output logic        rom_request_o,
  input  logic [7:0]  rom_data_i,
  input  logic        rom_valid_i
);

  localparam int unsigned RamDepth = 1 << RAM_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StRamWait, StRomWait, StRomDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        dvalid_q, dvalid_d;
  logic        rom_req_q, rom_req_d;
  logic [14:0] rom_addr_q, rom_addr_d;
  logic [15:0] acc_addr_q, acc_addr_d;
  logic        acc_write_q, acc_write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        last_write_q, last_write_d;
  logic        last_valid_q, last_valid_d;
  logic        prev_avalid_q;

  logic [7:0]  ram_q [RamDepth];

  logic        new_access;
  logic        start;
  logic [15:0] start_addr;
  logic        start_write;
  logic        acc_is_ram;
  logic        ram_we;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  assign new_access = address_valid_i &&
                      (!prev_avalid_q || !last_valid_q ||
                       (address_i != last_addr_q) || (write_i != last_write_q));
  assign acc_is_ram = (acc_addr_q[15:13] == 3'b000);
  assign ram_idx    = acc_addr_q[RAM_ADDR_WIDTH-1:0];

  // Next-state: access detection, FSM sequencing and the start of a (possibly pending) access
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    dvalid_d     = dvalid_q;
    rom_req_d    = rom_req_q;
    rom_addr_d   = rom_addr_q;
    acc_addr_d   = acc_addr_q;
    acc_write_d  = acc_write_q;
    wdata_d      = wdata_q;
    last_addr_d  = last_addr_q;
    last_write_d = last_write_q;
    last_valid_d = last_valid_q;
    start        = 1'b0;
    start_addr   = address_i;
    start_write  = write_i;
    ram_we       = 1'b0;

    if (new_access) begin
      acc_addr_d   = address_i;
      acc_write_d  = write_i;
      wdata_d      = write_data_i;
      last_addr_d  = address_i;
      last_write_d = write_i;
      last_valid_d = 1'b1;
      dvalid_d     = 1'b0;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (new_access) begin
          start = 1'b1;
        end else if (state_q == StDone && !address_valid_i) begin
          state_d  = StIdle;
          dvalid_d = 1'b0;
        end
      end
      StRamWait: begin
        if (new_access) begin
          start = 1'b1;
        end else if (cnt_q == 4'd0) begin
          // Unmapped accesses and ROM writes also land here with a zero count: open bus
          if (acc_is_ram) begin
            if (acc_write_q) begin
              ram_we = 1'b1;
              data_d = wdata_q;
            end else begin
              data_d = ram_q[ram_idx];
            end
          end
          dvalid_d = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRomWait: begin
        if (new_access) begin
          // An ack in the same cycle retires the old request, so the new access starts at once
          if (rom_valid_i) begin
            start = 1'b1;
          end else begin
            state_d = StRomDrain;
          end
        end else if (rom_valid_i) begin
          data_d    = rom_data_i;
          rom_req_d = 1'b0;
          dvalid_d  = 1'b1;
          state_d   = StDone;
        end
      end
      StRomDrain: begin
        if (rom_valid_i) begin
          start = 1'b1;
          if (!new_access) begin
            start_addr  = acc_addr_q;
            start_write = acc_write_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      rom_req_d = 1'b0;
      if (start_addr[15] && !start_write) begin
        state_d    = StRomWait;
        rom_req_d  = 1'b1;
        rom_addr_d = start_addr[14:0];
      end else if (start_addr[15:13] == 3'b000) begin
        state_d = StRamWait;
        cnt_d   = 4'(RAM_WAIT_STATES);
      end else begin
        state_d = StRamWait;
        cnt_d   = 4'd0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      data_q        <= 8'h00;
      dvalid_q      <= 1'b0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= 15'd0;
      acc_addr_q    <= 16'd0;
      acc_write_q   <= 1'b0;
      wdata_q       <= 8'h00;
      last_addr_q   <= 16'd0;
      last_write_q  <= 1'b0;
      last_valid_q  <= 1'b0;
      prev_avalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      dvalid_q      <= dvalid_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      acc_addr_q    <= acc_addr_d;
      acc_write_q   <= acc_write_d;
      wdata_q       <= wdata_d;
      last_addr_q   <= last_addr_d;
      last_write_q  <= last_write_d;
      last_valid_q  <= last_valid_d;
      prev_avalid_q <= address_valid_i;
    end
  end

  // Work RAM storage; contents deliberately survive reset
  always_ff @(posedge clock_i) begin
    if (ram_we) begin
      ram_q[ram_idx] <= wdata_q;
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = dvalid_q;
  assign rom_address_o = rom_addr_q;
  assign rom_request_o = rom_req_q;

endmodule

// File: tb/tb_cpu_memory_bus.sv
// Directed bench for cpu_memory_bus: vector table plus hand sequences for abort and reset cases.
module tb_cpu_memory_bus;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic [15:0] address_i;
  logic        address_valid_i;
  logic        write_i;
  logic [7:0]  write_data_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic [14:0] rom_address_o;
  logic        rom_request_o;
  logic [7:0]  rom_data_i;
  logic        rom_valid_i;

  int checks = 0;
  int errors = 0;

  cpu_memory_bus #(
    .RAM_WAIT_STATES(1),
    .RAM_ADDR_WIDTH (11)
  ) dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .address_i      (address_i),
    .address_valid_i(address_valid_i),
    .write_i        (write_i),
    .write_data_i   (write_data_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .rom_address_o  (rom_address_o),
    .rom_request_o  (rom_request_o),
    .rom_data_i     (rom_data_i),
    .rom_valid_i    (rom_valid_i)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          rom_delay;  // 0: no ROM ack; else edge index after detection carrying the ack
    logic [7:0]  rom_byte;
    int          exp_lat;    // edges after the detection edge until data_valid_o
    logic        chk_data;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one access, serve the ROM port if needed, measure latency and check the result
  task automatic run_vec(input vec_t v);
    int   lat;
    logic req_ok;
    address_i       = v.addr;
    write_i         = v.wr;
    write_data_i    = v.wdata;
    address_valid_i = 1'b1;
    tick;
    check($sformatf("valid_clear_%h", v.addr), 32'(data_valid_o), 32'd0);
    lat    = 0;
    req_ok = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      if (v.rom_delay != 0 && rom_request_o !== 1'b1) req_ok = 1'b0;
      rom_valid_i = (i == v.rom_delay);
      rom_data_i  = v.rom_byte;
      tick;
      rom_valid_i = 1'b0;
      if (data_valid_o === 1'b1) lat = i;
    end
    check($sformatf("latency_%h", v.addr), 32'(lat), 32'(v.exp_lat));
    if (v.chk_data) check($sformatf("data_%h", v.addr), 32'(data_o), 32'(v.exp_data));
    if (v.rom_delay != 0) begin
      check($sformatf("rom_req_held_%h", v.addr), 32'(req_ok), 32'd1);
      check($sformatf("rom_addr_%h", v.addr), 32'(rom_address_o), 32'(v.addr[14:0]));
    end
    check($sformatf("rom_req_idle_%h", v.addr), 32'(rom_request_o), 32'd0);
    address_valid_i = 1'b0;
    tick;
  endtask

  initial begin
    int   cnt;
    logic saw99;
    vec_t v;

    vecs[0] = '{16'h0012, 1'b1, 8'h5A, 0, 8'h00, 2, 1'b0, 8'h00};
    vecs[1] = '{16'h0812, 1'b0, 8'h00, 0, 8'h00, 2, 1'b1, 8'h5A};
    vecs[2] = '{16'hFFFC, 1'b0, 8'h00, 5, 8'h34, 5, 1'b1, 8'h34};
    vecs[3] = '{16'h1812, 1'b0, 8'h00, 0, 8'h00, 2, 1'b1, 8'h5A};
    vecs[4] = '{16'h4000, 1'b0, 8'h00, 0, 8'h00, 1, 1'b1, 8'h5A};
    vecs[5] = '{16'h8005, 1'b1, 8'h77, 0, 8'h00, 1, 1'b1, 8'h5A};
    vecs[6] = '{16'h07FF, 1'b1, 8'h11, 0, 8'h00, 2, 1'b0, 8'h00};
    vecs[7] = '{16'h1FFF, 1'b0, 8'h00, 0, 8'h00, 2, 1'b1, 8'h11};
    vecs[8] = '{16'h3000, 1'b1, 8'h22, 0, 8'h00, 1, 1'b1, 8'h11};

    reset_n_i       = 1'b0;
    address_i       = 16'h0000;
    address_valid_i = 1'b0;
    write_i         = 1'b0;
    write_data_i    = 8'h00;
    rom_data_i      = 8'h00;
    rom_valid_i     = 1'b0;
    tick;
    tick;
    check("reset_data", 32'(data_o), 32'h00);
    check("reset_valid", 32'(data_valid_o), 32'd0);
    check("reset_rom_req", 32'(rom_request_o), 32'd0);
    check("reset_rom_addr", 32'(rom_address_o), 32'd0);
    reset_n_i = 1'b1;
    tick;

    foreach (vecs[i]) run_vec(vecs[i]);

    // ROM read aborted by a RAM read: request held, ack discarded, then the RAM read completes
    address_i       = 16'h8765;
    write_i         = 1'b0;
    address_valid_i = 1'b1;
    tick;
    check("abort_req_rise", 32'(rom_request_o), 32'd1);
    check("abort_rom_addr", 32'(rom_address_o), 32'h0765);
    tick;
    address_i = 16'h0012;
    tick;
    check("drain_req_held", 32'(rom_request_o), 32'd1);
    check("drain_valid_low", 32'(data_valid_o), 32'd0);
    tick;
    tick;
    check("drain_req_still", 32'(rom_request_o), 32'd1);
    rom_valid_i = 1'b1;
    rom_data_i  = 8'h99;
    tick;
    rom_valid_i = 1'b0;
    check("drain_req_drop", 32'(rom_request_o), 32'd0);
    saw99 = (data_o === 8'h99);
    cnt   = 0;
    for (int i = 1; i <= 10 && cnt == 0; i++) begin
      tick;
      if (data_o === 8'h99) saw99 = 1'b1;
      if (data_valid_o === 1'b1) cnt = i;
    end
    check("drain_ram_latency", 32'(cnt), 32'd2);
    check("drain_ram_data", 32'(data_o), 32'h5A);
    check("drain_no_stale_rom", 32'(saw99), 32'd0);

    // Reset during a RAM write wait: the write must be lost
    address_valid_i = 1'b0;
    tick;
    address_i       = 16'h0012;
    write_i         = 1'b1;
    write_data_i    = 8'hAA;
    address_valid_i = 1'b1;
    tick;
    reset_n_i = 1'b0;
    #1;
    check("midreset_data", 32'(data_o), 32'h00);
    check("midreset_valid", 32'(data_valid_o), 32'd0);
    check("midreset_rom_req", 32'(rom_request_o), 32'd0);
    check("midreset_rom_addr", 32'(rom_address_o), 32'd0);
    address_valid_i = 1'b0;
    write_i         = 1'b0;
    tick;
    tick;
    reset_n_i = 1'b1;
    tick;
    v = '{16'h0012, 1'b0, 8'h00, 0, 8'h00, 2, 1'b1, 8'h5A};
    run_vec(v);

    // Valid dropped in DONE, then the same address re-presented is a fresh access
    address_i       = 16'h0012;
    write_i         = 1'b0;
    address_valid_i = 1'b1;
    tick;
    tick;
    tick;
    check("done_valid", 32'(data_valid_o), 32'd1);
    address_valid_i = 1'b0;
    tick;
    check("drop_valid_low", 32'(data_valid_o), 32'd0);
    check("drop_data_kept", 32'(data_o), 32'h5A);
    address_valid_i = 1'b1;
    tick;
    check("reassert_e0", 32'(data_valid_o), 32'd0);
    tick;
    check("reassert_e1", 32'(data_valid_o), 32'd0);
    tick;
    check("reassert_e2", 32'(data_valid_o), 32'd1);
    check("reassert_data", 32'(data_o), 32'h5A);

    // Stray ROM ack with no request outstanding is ignored
    address_valid_i = 1'b0;
    tick;
    rom_valid_i = 1'b1;
    rom_data_i  = 8'hEE;
    tick;
    rom_valid_i = 1'b0;
    tick;
    check("stray_ack_data", 32'(data_o), 32'h5A);
    check("stray_ack_valid", 32'(data_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
